// File: rtl/merge_pkg.sv
// Shared types and source tags for the 2:1 round-robin merge.
package merge_pkg;

  localparam int   DATA_W  = 8;
  localparam logic SRC_IN0 = 1'b0;
  localparam logic SRC_IN1 = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              src;
  } out_word_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter, purely combinational, one-hot grant.
// Zero latency; en low forces no grant so the caller can stall both requesters.
module rr_arb2
  import merge_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] gnt,
  output logic       gnt_idx
);

  logic req0_n, req1_n, last_n;
  logic only0, only1, both;
  logic win0, win1;

  assign req0_n = ~req[0];
  assign req1_n = ~req[1];
  assign last_n = ~last_grant;

  assign only0 = req[0] & req1_n;
  assign only1 = req[1] & req0_n;
  assign both  = req[0] & req[1];

  // On contention the side that did not win last time goes next.
  assign win0 = only0 | (both & last_grant);
  assign win1 = only1 | (both & last_n);

  assign gnt[0]  = en & win0;
  assign gnt[1]  = en & win1;
  assign gnt_idx = gnt[1];

endmodule

// File: rtl/merge_2to1_rr.sv
// Round-robin 2:1 stream merge with a source-tagged registered output; 1-cycle latency.
// Readies drop for both inputs while the output slot is full and not draining, or in reset.
module merge_2to1_rr
  import merge_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in0_data,
  input  logic             in0_valid,
  output logic             in0_ready,
  input  logic [WIDTH-1:0] in1_data,
  input  logic             in1_valid,
  output logic             in1_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_src,
  output logic             out_valid,
  input  logic             out_ready
);

  out_word_t  out_q;
  logic       out_valid_q;
  logic       last_grant;
  logic       can_accept;
  logic       arb_en;
  logic [1:0] gnt;
  logic       gnt_idx;
  logic       in_xfer;

  assign can_accept = ~out_valid_q | out_ready;
  assign arb_en     = rst_n & can_accept;

  rr_arb2 u_arb (
    .req        ({in1_valid, in0_valid}),
    .last_grant (last_grant),
    .en         (arb_en),
    .gnt        (gnt),
    .gnt_idx    (gnt_idx)
  );

  assign in0_ready = gnt[0];
  assign in1_ready = gnt[1];
  // A grant is only issued against a live request, so any grant is a transfer.
  assign in_xfer   = gnt[0] | gnt[1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      last_grant  <= SRC_IN1;
    end else if (in_xfer) begin
      out_q.data  <= gnt_idx ? in1_data : in0_data;
      out_q.src   <= gnt_idx;
      out_valid_q <= 1'b1;
      last_grant  <= gnt_idx;
    end else if (out_valid_q && out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_data  = out_q.data;
  assign out_src   = out_q.src;
  assign out_valid = out_valid_q;

endmodule
